// File: rtl/bram_arbiter.sv
// Round-robin arbiter that shares one single-port BRAM between requesters A and B.
// Each access goes through IDLE -> ISSUE (-> READ_WAIT for reads) -> IDLE.
module bram_arbiter #(
  parameter int DATA_WIDTH = 60,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    READ_WAIT
  } state_t;

  state_t state;
  logic   owner;       // 0 = A, 1 = B
  logic   last_owner;  // 0 = A, 1 = B
  logic   win_b;

  // On a tie the requester that did not go last wins.
  always_comb begin
    win_b = b_req && (!a_req || !last_owner);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b1;
      last_owner <= 1'b1;
      a_gnt      <= 1'b0;
      b_gnt      <= 1'b0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else begin
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            owner      <= win_b;
            last_owner <= win_b;
            ram_addr   <= win_b ? b_addr : a_addr;
            ram_din    <= win_b ? b_din  : a_din;
            ram_we     <= win_b ? b_we   : a_we;
            a_gnt      <= !win_b;
            b_gnt      <= win_b;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          ram_we <= 1'b0;
          // ram_we still holds the owner's write flag during ISSUE.
          if (ram_we) begin
            state <= IDLE;
          end else begin
            a_rvalid <= !owner;
            b_rvalid <= owner;
            state    <= READ_WAIT;
          end
        end
        READ_WAIT: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state != IDLE);
    a_rdata = a_rvalid ? ram_dout : '0;
    b_rdata = b_rvalid ? ram_dout : '0;
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Randomized bench for bram_arbiter: a cycle-scheduled transaction model predicts
// every grant, read-data return and memory-port value from the arbitration rules.
module tb_bram_arbiter;
  localparam int DW = 60;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, busy, ram_we;
  logic [DW-1:0] a_rdata, b_rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  logic          req_v [2];
  logic          we_v  [2];
  logic [AW-1:0] addr_v[2];
  logic [DW-1:0] din_v [2];

  bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(req_v[0]), .a_we(we_v[0]), .a_addr(addr_v[0]), .a_din(din_v[0]),
    .b_req(req_v[1]), .b_we(we_v[1]), .b_addr(addr_v[1]), .b_din(din_v[1]),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port BRAM with one cycle of read latency.
  logic [DW-1:0] ram [16];
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = '0;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference model state: expectations are scheduled into an 8-deep cycle ring.
  int            cyc = 0;
  int            next_arb = 1;
  logic          last_owner = 1'b1;
  logic [DW-1:0] mem_m [16];
  logic          e_ag[8], e_bg[8], e_ar[8], e_br[8], e_iss[8], e_we[8];
  logic [AW-1:0] e_addr[8];
  logic [DW-1:0] e_din[8], e_rd[8];

  logic          pending[2], glitch[2], inj[2], inj_we[2];
  logic [AW-1:0] inj_addr[2];
  logic [DW-1:0] inj_din[2];
  int            gnt_cyc[2];
  int            p_req = 0, p_again = 0, p_glitch = 0;
  logic          force_read = 1'b0;
  int            we_count = 0;

  function automatic logic [DW-1:0] rand_data();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      e_ag[i] = 0; e_bg[i] = 0; e_ar[i] = 0; e_br[i] = 0; e_iss[i] = 0; e_we[i] = 0;
      e_addr[i] = '0; e_din[i] = '0; e_rd[i] = '0;
    end
    for (int r = 0; r < 2; r++) begin
      pending[r] = 0; glitch[r] = 0; inj[r] = 0; gnt_cyc[r] = -10;
      req_v[r] = 0; we_v[r] = 0; addr_v[r] = '0; din_v[r] = '0;
    end
    last_owner = 1'b1;
    next_arb   = cyc + 1;
  endtask

  task automatic start_req(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pending[r] = 1; gnt_cyc[r] = -10;
    req_v[r] = 1; we_v[r] = we; addr_v[r] = a; din_v[r] = d;
  endtask

  task automatic start_random(input int r);
    logic we;
    we = force_read ? 1'b0 : 1'($urandom_range(1, 0));
    start_req(r, we, AW'($urandom_range(15, 0)), rand_data());
  endtask

  task automatic inject(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    inj[r] = 1; inj_we[r] = we; inj_addr[r] = a; inj_din[r] = d;
  endtask

  task automatic check_outputs();
    int s;
    s = cyc % 8;
    check("a_gnt", a_gnt, e_ag[s]);
    check("b_gnt", b_gnt, e_bg[s]);
    check("a_rvalid", a_rvalid, e_ar[s]);
    check("b_rvalid", b_rvalid, e_br[s]);
    check("a_rdata", a_rdata, e_ar[s] ? e_rd[s] : '0);
    check("b_rdata", b_rdata, e_br[s] ? e_rd[s] : '0);
    check("busy", busy, cyc != next_arb);
    check("ram_we", ram_we, e_iss[s] && e_we[s]);
    if (e_iss[s]) begin
      check("ram_addr", ram_addr, e_addr[s]);
      check("ram_din", ram_din, e_din[s]);
    end
    if (ram_we) we_count++;
    e_ag[s] = 0; e_bg[s] = 0; e_ar[s] = 0; e_br[s] = 0; e_iss[s] = 0; e_we[s] = 0;
  endtask

  task automatic drive();
    for (int r = 0; r < 2; r++) begin
      if (pending[r] && gnt_cyc[r] == cyc - 1) begin
        pending[r] = 0;
        req_v[r]   = 0;
        if ($urandom_range(99, 0) < p_again) start_random(r);
      end else if (glitch[r]) begin
        glitch[r] = 0;
        req_v[r]  = 0;
      end else if (!pending[r]) begin
        if (inj[r]) begin
          inj[r] = 0;
          start_req(r, inj_we[r], inj_addr[r], inj_din[r]);
        end else if ($urandom_range(99, 0) < p_req) begin
          start_random(r);
        end else if (cyc != next_arb && $urandom_range(99, 0) < p_glitch) begin
          glitch[r] = 1;
          req_v[r]  = 1;
          we_v[r]   = 1'($urandom_range(1, 0));
          addr_v[r] = AW'($urandom_range(15, 0));
          din_v[r]  = rand_data();
        end
      end
    end
  endtask

  task automatic model_step();
    int w, s1, s2;
    if (cyc != next_arb) return;
    if (!req_v[0] && !req_v[1]) begin
      next_arb = cyc + 1;
      return;
    end
    if (req_v[0] && req_v[1]) w = (last_owner == 1'b0) ? 1 : 0;
    else w = req_v[0] ? 0 : 1;
    last_owner = 1'(w);
    s1 = (cyc + 1) % 8;
    if (w == 0) e_ag[s1] = 1; else e_bg[s1] = 1;
    e_iss[s1] = 1; e_we[s1] = we_v[w]; e_addr[s1] = addr_v[w]; e_din[s1] = din_v[w];
    gnt_cyc[w] = cyc + 1;
    if (we_v[w]) begin
      mem_m[addr_v[w]] = din_v[w];
      next_arb = cyc + 2;
    end else begin
      s2 = (cyc + 2) % 8;
      if (w == 0) e_ar[s2] = 1; else e_br[s2] = 1;
      e_rd[s2] = mem_m[addr_v[w]];
      next_arb = cyc + 3;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    drive();
    model_step();
  endtask

  task automatic drain();
    int k;
    k = 0;
    p_req = 0; p_again = 0; p_glitch = 0;
    while ((pending[0] || pending[1] || inj[0] || inj[1] || glitch[0] || glitch[1] ||
            next_arb != cyc + 1) && k < 60) begin
      step();
      k++;
    end
    check("drain_bound", k < 60, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ram_we"}, ram_we, 1'b0);
    check({tag, "_gnt"}, {a_gnt, b_gnt}, 2'b00);
    check({tag, "_rvalid"}, {a_rvalid, b_rvalid}, 2'b00);
    check({tag, "_ram_addr"}, ram_addr, '0);
    check({tag, "_ram_din"}, ram_din, '0);
    check({tag, "_rdata"}, a_rdata | b_rdata, '0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    model_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1;
    model_reset();

    // First tie after reset goes to A; two writes give two ram_we cycles.
    we_count = 0;
    inject(0, 1'b1, 4'd1, rand_data());
    inject(1, 1'b1, 4'd2, rand_data());
    drain();
    check("tie_we_cycles", we_count, 2);

    inject(0, 1'b1, 4'd3, 60'h123);
    drain();
    inject(0, 1'b0, 4'd3, '0);
    drain();
    inject(1, 1'b1, 4'd15, 60'hFFF);
    drain();
    inject(1, 1'b0, 4'd15, '0);
    drain();

    // Random traffic including short req pulses while the arbiter is busy.
    p_req = 35; p_again = 30; p_glitch = 30;
    repeat (400) step();
    drain();

    // Reset while an A read sits in READ_WAIT.
    inject(0, 1'b0, 4'd3, '0);
    step(); step(); step();
    rst_n = 0;
    #1;
    check_reset_values("rst_rw");
    @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    @(negedge clk);
    rst_n = 1;
    model_reset();
    inject(0, 1'b0, 4'd3, '0);
    inject(1, 1'b0, 4'd15, '0);
    drain();

    // Both requesters continuously reading: grants must alternate.
    force_read = 1'b1;
    p_req = 100; p_again = 100;
    repeat (60) step();
    force_read = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
